// File: rtl/pipe_hazard_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, bubble instruction, mux encodings, decode record and controller states
package riscv_ctrl_pkg;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0] PC_JUMP = 2'd0, PC_ALU = 2'd1, PC_PLUS4 = 2'd2;
   localparam logic [1:0] FWD_RF = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2;
   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rs1_used;
      logic       rs2_used;
      logic       rd_wr;
      logic       load;
      logic       store;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic       brun;
   } dec_t;
endpackage

// File: rtl/pipe_hazard_ctrl_decode.sv
// rv_inst_decode: register-use and instruction-class decode of one RV32I instruction
module rv_inst_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [31:0] i_inst,
   output dec_t        o_dec
);
   logic [6:0] w_op;
   logic       w_load, w_store, w_branch, w_jal, w_jalr, w_alu, w_rs1_used, w_rd_wr;
   assign w_op       = i_inst[6:0];
   assign w_load     = w_op == OP_LOAD;
   assign w_store    = w_op == OP_STORE;
   assign w_branch   = w_op == OP_BRANCH;
   assign w_jal      = w_op == OP_JAL;
   assign w_jalr     = w_op == OP_JALR;
   assign w_alu      = w_op == OP_IMM || w_op == OP_REG;
   assign w_rs1_used = w_load || w_store || w_branch || w_jalr || w_alu;
   // x0 is never a real destination, so it is folded out here once for every consumer
   assign w_rd_wr    = (w_load || w_jal || w_jalr || w_alu || w_op == OP_LUI || w_op == OP_AUIPC)
                       && i_inst[11:7] != 5'd0;
   assign o_dec = '{rs1: i_inst[19:15], rs2: i_inst[24:20], rd: i_inst[11:7],
                    rs1_used: w_rs1_used, rs2_used: w_store || w_branch || w_op == OP_REG,
                    rd_wr: w_rd_wr, load: w_load, store: w_store, branch: w_branch,
                    jal: w_jal, jalr: w_jalr, brun: w_branch && i_inst[13]};
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: FD/X/MW pipeline controller with stall, flush, memory-wait sequencing and perf counters
module pipe_hazard_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int          BRANCH_PENALTY = 1,
   parameter bit          LOAD_USE_STALL = 1'b1,
   parameter int          CNT_W          = 16,
   parameter logic [31:0] NOP_INST       = NOP
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_inst_fd,
   input  logic             i_br_taken,
   input  logic             i_mem_busy,
   output logic [31:0]      o_inst_x,
   output logic [31:0]      o_inst_mw,
   output logic             o_pc_hold,
   output logic [1:0]       o_pc_sel,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic             o_wb2d_a,
   output logic             o_wb2d_b,
   output logic             o_reg_wen,
   output logic             o_brun,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic [CNT_W-1:0] o_memwait_cnt
);
   localparam int FD = 0, X = 1, MW = 2;
   state_t           r_state, w_state_nxt, w_cur;
   logic [1:0]       r_fcnt, w_fcnt_nxt;
   logic [31:0]      r_x, r_mw;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_memwait_cnt;
   logic [2:0][31:0] w_inst;
   dec_t             w_dec [3];
   logic             w_wait, w_redirect, w_lu;

   function automatic logic [1:0] fwd_src(input logic used, input logic [4:0] rs, input dec_t p);
      return (p.rd_wr && used && rs == p.rd) ? ((!LOAD_USE_STALL && p.load) ? FWD_MEM : FWD_WB) : FWD_RF;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return c + CNT_W'(en && c != '1);
   endfunction

   assign w_inst = {r_mw, r_x, i_inst_fd};
   for (genvar g = 0; g < 3; g++) begin : g_dec
      rv_inst_decode u_dec (.i_inst(w_inst[g]), .o_dec(w_dec[g]));
   end

   // w_cur is the state this cycle acts in; r_state only remembers pending flush bubbles across waits
   always_comb begin
      w_wait      = i_mem_busy && (w_dec[MW].load || w_dec[MW].store);
      w_redirect  = w_dec[X].jal || w_dec[X].jalr || (w_dec[X].branch && i_br_taken);
      w_lu        = LOAD_USE_STALL && w_dec[X].load && w_dec[X].rd_wr
                    && ((w_dec[FD].rs1_used && w_dec[FD].rs1 == w_dec[X].rd)
                    ||  (w_dec[FD].rs2_used && w_dec[FD].rs2 == w_dec[X].rd));
      w_cur       = w_wait ? MEM_WAIT : (w_redirect || r_state == FLUSH) ? FLUSH : w_lu ? LU_STALL : RUN;
      w_fcnt_nxt  = w_wait ? r_fcnt : w_redirect ? 2'(BRANCH_PENALTY - 1)
                  : (r_fcnt != 2'd0) ? r_fcnt - 2'd1 : 2'd0;
      w_state_nxt = w_wait ? r_state : (w_fcnt_nxt != 2'd0) ? FLUSH : RUN;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= RUN;
         r_fcnt        <= 2'd0;
         r_x           <= NOP_INST;
         r_mw          <= NOP_INST;
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
         r_memwait_cnt <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_fcnt        <= w_fcnt_nxt;
         if (w_cur != MEM_WAIT) begin
            r_mw <= r_x;
            r_x  <= (w_cur == RUN) ? i_inst_fd : NOP_INST;
         end
         r_stall_cnt   <= sat_inc(r_stall_cnt, w_cur == LU_STALL);
         r_flush_cnt   <= sat_inc(r_flush_cnt, w_cur == FLUSH);
         r_memwait_cnt <= sat_inc(r_memwait_cnt, w_cur == MEM_WAIT);
      end
   end

   assign o_inst_x      = r_x;
   assign o_inst_mw     = r_mw;
   assign o_pc_hold     = w_cur == MEM_WAIT || w_cur == LU_STALL;
   assign o_pc_sel      = w_dec[X].jal ? PC_JUMP : w_redirect ? PC_ALU : PC_PLUS4;
   assign o_fwd_a       = fwd_src(w_dec[X].rs1_used, w_dec[X].rs1, w_dec[MW]);
   assign o_fwd_b       = fwd_src(w_dec[X].rs2_used, w_dec[X].rs2, w_dec[MW]);
   assign o_wb2d_a      = w_dec[MW].rd_wr && w_dec[FD].rs1_used && w_dec[FD].rs1 == w_dec[MW].rd;
   assign o_wb2d_b      = w_dec[MW].rd_wr && w_dec[FD].rs2_used && w_dec[FD].rs2 == w_dec[MW].rd;
   assign o_reg_wen     = w_dec[MW].rd_wr && !w_wait;
   assign o_brun        = w_dec[X].brun;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;
   assign o_memwait_cnt = r_memwait_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of two controller configurations against a pipeline model
module tb_pipe_hazard_ctrl;
   localparam logic [31:0] NOPI = 32'h13, LW = 32'h0000a283, ADD = 32'h00528333, BEQ = 32'h00000463;
   localparam logic [31:0] SW = 32'h00112023, ADDI1 = 32'h00500093, ADDI0 = 32'h00500013;
   localparam logic [31:0] JAL1 = 32'h008000ef, ADD00 = 32'h00000333;
   logic clk = 1'b0, rst_n = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;
   logic [31:0] inst_fd = NOPI;
   logic [31:0] x0, x1, mw0, mw1;
   logic        ph0, ph1, wa0, wa1, wb0, wb1, wen0, wen1, bu0, bu1;
   logic [1:0]  ps0, ps1, fa0, fa1, fb0, fb1;
   logic [15:0] sc0, fc0, mc0;
   logic [2:0]  sc1, fc1, mc1;
   int          n_chk = 0, n_err = 0;
   bit          armed = 1'b0;
   logic [31:0] m_x [2], m_mw [2];
   int          m_pend [2], m_s [2], m_f [2], m_m [2];
   int          bp [2] = '{1, 2};
   bit          lus [2] = '{1'b1, 1'b0};
   int          cmax [2] = '{65535, 7};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.BRANCH_PENALTY(1), .LOAD_USE_STALL(1'b1), .CNT_W(16)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inst_fd(inst_fd), .i_br_taken(br_taken), .i_mem_busy(mem_busy),
      .o_inst_x(x0), .o_inst_mw(mw0), .o_pc_hold(ph0), .o_pc_sel(ps0), .o_fwd_a(fa0), .o_fwd_b(fb0),
      .o_wb2d_a(wa0), .o_wb2d_b(wb0), .o_reg_wen(wen0), .o_brun(bu0),
      .o_stall_cnt(sc0), .o_flush_cnt(fc0), .o_memwait_cnt(mc0));

   pipe_hazard_ctrl #(.BRANCH_PENALTY(2), .LOAD_USE_STALL(1'b0), .CNT_W(3)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_inst_fd(inst_fd), .i_br_taken(br_taken), .i_mem_busy(mem_busy),
      .o_inst_x(x1), .o_inst_mw(mw1), .o_pc_hold(ph1), .o_pc_sel(ps1), .o_fwd_a(fa1), .o_fwd_b(fb1),
      .o_wb2d_a(wa1), .o_wb2d_b(wb1), .o_reg_wen(wen1), .o_brun(bu1),
      .o_stall_cnt(sc1), .o_flush_cnt(fc1), .o_memwait_cnt(mc1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit writes(input logic [31:0] i);
      return i[6:0] inside {7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67} && i[11:7] != 5'd0;
   endfunction
   function automatic bit reads1(input logic [31:0] i);
      return i[6:0] inside {7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h67};
   endfunction
   function automatic bit reads2(input logic [31:0] i);
      return i[6:0] inside {7'h23, 7'h63, 7'h33};
   endfunction
   function automatic logic [1:0] hits(input logic [31:0] p, input logic [31:0] c);
      return {writes(p) && reads2(c) && c[24:20] == p[11:7], writes(p) && reads1(c) && c[19:15] == p[11:7]};
   endfunction
   function automatic bit redir(input logic [31:0] x);
      return x[6:0] == 7'h6f || x[6:0] == 7'h67 || (x[6:0] == 7'h63 && br_taken);
   endfunction
   function automatic bit lu_hit(input int k, input logic [31:0] x);
      return lus[k] && x[6:0] == 7'h03 && hits(x, inst_fd) != 2'b00;
   endfunction
   function automatic bit waiting(input logic [31:0] mw);
      return mem_busy && mw[6:0] inside {7'h03, 7'h23};
   endfunction

   task automatic check_comb(input int k);
      logic [31:0] x, mw;
      logic [1:0]  fh, wh, src;
      bit          wt, rdr;
      string       u;
      x   = m_x[k];
      mw  = m_mw[k];
      wt  = waiting(mw);
      rdr = redir(x);
      fh  = hits(mw, x);
      wh  = hits(mw, inst_fd);
      src = (!lus[k] && mw[6:0] == 7'h03) ? 2'd2 : 2'd1;
      u   = k == 0 ? "u0" : "u1";
      check({u, ".pc_hold"}, k == 0 ? ph0 : ph1, 32'(wt || (!rdr && m_pend[k] == 0 && lu_hit(k, x))));
      check({u, ".pc_sel"}, k == 0 ? ps0 : ps1, x[6:0] == 7'h6f ? 0 : rdr ? 1 : 2);
      check({u, ".fwd_a"}, k == 0 ? fa0 : fa1, fh[0] ? src : 2'd0);
      check({u, ".fwd_b"}, k == 0 ? fb0 : fb1, fh[1] ? src : 2'd0);
      check({u, ".wb2d_a"}, k == 0 ? wa0 : wa1, wh[0]);
      check({u, ".wb2d_b"}, k == 0 ? wb0 : wb1, wh[1]);
      check({u, ".reg_wen"}, k == 0 ? wen0 : wen1, 32'(writes(mw) && !wt));
      check({u, ".brun"}, k == 0 ? bu0 : bu1, 32'(x[6:0] == 7'h63 && x[13]));
   endtask

   task automatic advance(input int k);
      logic [31:0] x, mw;
      x  = m_x[k];
      mw = m_mw[k];
      if (!rst_n) begin
         m_x[k] = NOPI; m_mw[k] = NOPI; m_pend[k] = 0; m_s[k] = 0; m_f[k] = 0; m_m[k] = 0;
      end else if (waiting(mw)) begin
         m_m[k] = m_m[k] < cmax[k] ? m_m[k] + 1 : m_m[k];
      end else begin
         m_mw[k] = x;
         if (redir(x) || m_pend[k] > 0) begin
            m_pend[k] = redir(x) ? bp[k] - 1 : m_pend[k] - 1;
            m_x[k]    = NOPI;
            m_f[k]    = m_f[k] < cmax[k] ? m_f[k] + 1 : m_f[k];
         end else if (lu_hit(k, x)) begin
            m_x[k] = NOPI;
            m_s[k] = m_s[k] < cmax[k] ? m_s[k] + 1 : m_s[k];
         end else
            m_x[k] = inst_fd;
      end
   endtask

   task automatic check_regs(input int k);
      string u;
      u = k == 0 ? "u0" : "u1";
      check({u, ".inst_x"}, k == 0 ? x0 : x1, m_x[k]);
      check({u, ".inst_mw"}, k == 0 ? mw0 : mw1, m_mw[k]);
      check({u, ".stall_cnt"}, k == 0 ? 32'(sc0) : 32'(sc1), m_s[k]);
      check({u, ".flush_cnt"}, k == 0 ? 32'(fc0) : 32'(fc1), m_f[k]);
      check({u, ".memwait_cnt"}, k == 0 ? 32'(mc0) : 32'(mc1), m_m[k]);
   endtask

   task automatic drive(input logic [31:0] fd, input logic br = 1'b0, input logic busy = 1'b0, input logic rst = 1'b1);
      @(negedge clk);
      inst_fd  = fd;
      br_taken = br;
      mem_busy = busy;
      rst_n    = rst;
      #1;
      if (armed) for (int k = 0; k < 2; k++) check_comb(k);
   endtask

   task automatic tick();
      for (int k = 0; k < 2; k++) advance(k);
      @(posedge clk);
      #1;
      armed = 1'b1;
      for (int k = 0; k < 2; k++) check_regs(k);
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [4:0] rd, a, b;
      rd = 5'($urandom_range(0, 3));
      a  = 5'($urandom_range(0, 3));
      b  = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 8))
         0:       return {7'h0, b, a, 3'h0, rd, 7'h33};
         1:       return {12'h5, a, 3'h0, rd, 7'h13};
         2:       return {12'h4, a, 3'h2, rd, 7'h03};
         3:       return {7'h0, b, a, 3'h2, 5'h4, 7'h23};
         4:       return {7'h0, b, a, 3'($urandom_range(0, 7)), 5'h8, 7'h63};
         5:       return {20'h00800, rd, 7'h6f};
         6:       return {12'h0, a, 3'h0, rd, 7'h67};
         7:       return {20'h12345, rd, 7'h37};
         default: return {20'h0, rd, 7'h17};
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         drive(ADDI1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      check("rst.inst_x", x0, NOPI);
      check("rst.inst_mw", mw1, NOPI);
      check("rst.reg_wen", wen0, 0);
      check("rst.counters", 32'(sc0) + 32'(fc0) + 32'(mc0) + 32'(sc1) + 32'(fc1) + 32'(mc1), 0);
      drive(LW); tick();
      drive(ADD);
      check("lu.hold_stall", ph0, 1);
      check("lu.hold_fwdmode", ph1, 0);
      tick();
      drive(ADD);
      check("lu.wb2d_a", wa0, 1);
      check("lu.wb2d_b", wb0, 1);
      check("lu.fwd_a_mem", fa1, 2);
      check("lu.fwd_b_mem", fb1, 2);
      tick();
      check("lu.stall_cnt", sc0, 1);
      check("lu.no_stall_cnt", sc1, 0);
      repeat (2) begin drive(NOPI); tick(); end
      drive(BEQ); tick();
      drive(ADDI1, 1'b1);
      check("br.pc_sel0", ps0, 1);
      check("br.pc_sel1", ps1, 1);
      tick();
      drive(ADDI1); tick();
      check("br.x_after1", x0, ADDI1);
      check("br.x_after2", x1, NOPI);
      check("br.flush_cnt1", fc0, 1);
      check("br.flush_cnt2", fc1, 2);
      drive(BEQ); tick();
      drive(ADDI1);
      check("bnt.pc_sel", ps0, 2);
      tick();
      check("bnt.x", x0, ADDI1);
      check("bnt.flush_cnt", fc0, 1);
      drive(SW); tick();
      drive(NOPI); tick();
      for (int i = 0; i < 3; i++) begin
         drive(NOPI, 1'b0, 1'b1);
         check("mw.pc_hold", ph0, 1);
         tick();
      end
      check("mw.frozen_mw", mw0, SW);
      check("mw.memwait_cnt0", mc0, 3);
      check("mw.memwait_cnt1", mc1, 3);
      drive(NOPI); tick();
      drive(SW); tick();
      drive(JAL1); tick();
      drive(NOPI, 1'b0, 1'b1);
      check("jw.hold", ph0, 1);
      tick();
      check("jw.frozen_x", x0, JAL1);
      drive(NOPI);
      check("jw.pc_sel", ps0, 0);
      tick();
      drive(ADDI0); tick();
      drive(ADD00); tick();
      drive(NOPI);
      check("x0.fwd_a", fa0, 0);
      check("x0.reg_wen", wen0, 0);
      tick();
      drive(SW); tick();
      drive(NOPI); tick();
      drive(NOPI, 1'b0, 1'b1); tick();
      drive(NOPI, 1'b0, 1'b1, 1'b0); tick();
      check("rstw.inst_mw", mw0, NOPI);
      check("rstw.memwait_cnt", mc0, 0);
      for (int i = 0; i < 1500; i++) begin
         drive(rnd_inst(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 63) != 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
